uart_rx_checked: RTL and testbench

- Checked UART receiver: the receiving end for frames produced by tx_module, including its optional parity bit.
- 16x oversampled, majority-voted bit sampling. Detects parity errors, framing errors and overrun.
- Delivers each byte through a valid/ready holding register to the downstream consumer.
- Intended as the line-side receiver in the UART datapath.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_os_tick.sv | 43 ++++
 rtl/uart_rx_checked.sv | 140 ++++++++++++++
 tb/tb_uart_rx_checked.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, oversample ratio, baud-rate table.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int unsigned OSR = 16;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       parity_err;
    logic       frame_err;
  } rx_byte_t;

  // Rate table shared with tx_module; keep both ends in step.
  function automatic int unsigned baud_rate(input logic [2:0] sel);
    case (sel)
      3'd0:    return 4800;
      3'd1:    return 9600;
      3'd2:    return 19200;
      3'd3:    return 38400;
      3'd4:    return 57600;
      3'd5:    return 115200;
      3'd6:    return 230400;
      default: return 460800;
    endcase
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// 16x oversample tick generator: one-clk pulse every floor(FCLK/(16*rate)) clocks.
// Latency: first tick arrives one divisor period after restart.
// Backpressure: none; free-running apart from the synchronous restart.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int unsigned FCLK = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic [2:0] baud_sel,
  output logic       tick
);

  logic [19:0] div_tab [8];
  logic [19:0] cnt;
  logic        last;

  // Each entry folds to a constant, so no runtime divider is built.
  for (genvar i = 0; i < 8; i++) begin : g_div
    assign div_tab[i] = 20'(FCLK / (OSR * baud_rate(3'(i))));
  end

  assign last = (cnt == div_tab[baud_sel] - 20'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (last) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 20'd1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_checked.sv
// Checked UART receiver: 16x oversampled, majority-voted, even parity, framing/overrun detection.
// Latency: data_out_valid rises 2 sync + 1 clk after the stop-bit majority point.
// Backpressure: single holding register; a frame completing while it is full and not draining is dropped.
module uart_rx_checked
  import uart_pkg::*;
#(
  parameter int unsigned fclk = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic [2:0] baud,
  input  logic       parity_en,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  logic       rxd_m, rxd_s, rxd_q;
  rx_state_t  state_q, state_d;
  logic [2:0] baud_q;
  logic       parity_en_q;
  logic       tick;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       smp7, smp8, par_q;
  logic       start_det, at_mid, at_end, maj, stop_dec, xfer;
  logic       done_q;
  rx_byte_t   done_byte_q, hold_q;
  logic       vld_q, ovr_q;

  assign start_det = (state_q == IDLE) && rxd_q && !rxd_s;
  assign at_mid    = tick && (tick_cnt == 4'd9);
  assign at_end    = tick && (tick_cnt == 4'd15);
  assign maj       = (smp7 & smp8) | (smp7 & rxd_s) | (smp8 & rxd_s);
  assign stop_dec  = (state_q == STOP) && at_mid;
  assign xfer      = vld_q && data_out_ready;

  uart_os_tick #(.FCLK(fclk)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .restart  (start_det),
    .baud_sel (baud_q),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Stop is decided mid-bit so a following start edge is never missed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_det) state_d = START;
      START:   if (at_mid && maj) state_d = IDLE;
               else if (at_end) state_d = DATA;
      DATA:    if (at_end && bit_cnt == 3'd7) state_d = parity_en_q ? PARITY : STOP;
      PARITY:  if (at_end) state_d = STOP;
      STOP:    if (at_mid) state_d = maj ? IDLE : BREAK;
      BREAK:   if (rxd_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_m       <= 1'b1;
      rxd_s       <= 1'b1;
      rxd_q       <= 1'b1;
      baud_q      <= '0;
      parity_en_q <= 1'b0;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      smp7        <= 1'b1;
      smp8        <= 1'b1;
      par_q       <= 1'b0;
      done_q      <= 1'b0;
      done_byte_q <= '0;
    end else begin
      rxd_m  <= rxd;
      rxd_s  <= rxd_m;
      rxd_q  <= rxd_s;
      done_q <= stop_dec;
      if (start_det) begin
        baud_q      <= baud;
        parity_en_q <= parity_en;
        tick_cnt    <= '0;
        bit_cnt     <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 4'd1;
        if (tick_cnt == 4'd7) smp7 <= rxd_s;
        if (tick_cnt == 4'd8) smp8 <= rxd_s;
        if (at_mid && state_q == DATA)   shreg <= {maj, shreg[7:1]};
        if (at_mid && state_q == PARITY) par_q <= maj;
        if (at_end && state_q == DATA)   bit_cnt <= bit_cnt + 3'd1;
      end
      if (stop_dec)
        done_byte_q <= '{data:       shreg,
                         parity_err: parity_en_q & (^shreg ^ par_q),
                         frame_err:  ~maj};
    end
  end

  // Holding register: a same-cycle drain makes room for the new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done_q) begin
        if (!vld_q || xfer) begin
          hold_q <= done_byte_q;
          vld_q  <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (xfer) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign data_out       = hold_q.data;
  assign parity_err     = hold_q.parity_err;
  assign frame_err      = hold_q.frame_err;
  assign data_out_valid = vld_q;
  assign overrun        = ovr_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_checked.sv
// Scoreboard bench for uart_rx_checked: frames driven on rxd, expected bytes queued, checked on transfer.
module tb_uart_rx_checked;

  localparam int unsigned FCLK = 7_372_800;  // divisor 4 at baud=5, 2 at baud=6
  localparam int BIT5 = 64;
  localparam int BIT6 = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [2:0] baud;
  logic       parity_en;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   ovr_seen = 0;

  always #5 clk = ~clk;

  uart_rx_checked #(.fclk(FCLK)) dut (
    .clk            (clk),
    .rst            (rst),
    .rxd            (rxd),
    .baud           (baud),
    .parity_en      (parity_en),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .parity_err     (parity_err),
    .frame_err      (frame_err),
    .overrun        (overrun),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v, input int n);
    rxd = v;
    wait_clks(n);
  endtask

  // Line is left at the stop-bit level so a low stop can run straight into a break.
  task automatic send_frame(input logic [7:0] b, input logic pen, input logic pbit,
                            input logic stop, input int n);
    send_bit(1'b0, n);
    for (int i = 0; i < 8; i++) send_bit(b[i], n);
    if (pen) send_bit(pbit, n);
    send_bit(stop, n);
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    sb.push_back('{d: d, pe: pe, fe: fe});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) ovr_seen++;
      if (data_out_valid && data_out_ready) begin
        if (sb.size() == 0) begin
          chk("xfer_pending", 32'(sb.size()), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          chk("xfer", 32'({data_out, parity_err, frame_err}), 32'(mon_e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    rst = 1'b1;
    rxd = 1'b1;
    baud = 3'd5;
    parity_en = 1'b0;
    data_out_ready = 1'b1;
    wait_clks(10);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(data_out_valid), 32'h0);
    chk("rst_perr", 32'(parity_err), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    wait_clks(2 * 11 * BIT5);
    chk("idle_valid", 32'(data_out_valid), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // clean byte with even parity
    parity_en = 1'b1;
    b = 8'h55;
    push(b, 1'b0, 1'b0);
    send_frame(b, 1'b1, ^b, 1'b1, BIT5);
    wait_clks(BIT5);
    chk("clean_drained", 32'(sb.size()), 32'd0);

    // wrong parity bit
    b = 8'hA3;
    push(b, 1'b1, 1'b0);
    send_frame(b, 1'b1, ~(^b), 1'b1, BIT5);
    wait_clks(BIT5);
    chk("perr_drained", 32'(sb.size()), 32'd0);

    // low stop bit followed by break
    b = 8'h0F;
    push(b, 1'b0, 1'b1);
    send_frame(b, 1'b1, ^b, 1'b0, BIT5);
    wait_clks(3 * BIT5);
    chk("break_busy", 32'(busy), 32'h1);
    chk("break_drained", 32'(sb.size()), 32'd0);
    rxd = 1'b1;
    wait_clks(8);
    chk("break_idle", 32'(busy), 32'h0);
    wait_clks(2 * BIT5);

    // 3-tick glitch on idle line
    rxd = 1'b0;
    wait_clks(12);
    rxd = 1'b1;
    chk("glitch_busy", 32'(busy), 32'h1);
    wait_clks(80);
    chk("glitch_idle", 32'(busy), 32'h0);
    chk("glitch_valid", 32'(data_out_valid), 32'h0);

    // baud/parity_en changed mid-frame must not affect the frame
    baud = 3'd6;
    parity_en = 1'b0;
    push(8'hC6, 1'b0, 1'b0);
    fork
      send_frame(8'hC6, 1'b0, 1'b0, 1'b1, BIT6);
      begin
        wait_clks(40);
        baud = 3'd0;
        parity_en = 1'b1;
      end
    join
    wait_clks(BIT5);
    chk("latch_drained", 32'(sb.size()), 32'd0);
    baud = 3'd5;
    parity_en = 1'b0;

    // back-to-back frames into a stalled consumer
    data_out_ready = 1'b0;
    push(8'h12, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, BIT5);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1, BIT5);
    wait_clks(BIT5);
    chk("ovr_count", 32'(ovr_seen), 32'd1);
    chk("ovr_hold_data", 32'(data_out), 32'h12);
    chk("ovr_hold_valid", 32'(data_out_valid), 32'h1);
    data_out_ready = 1'b1;
    wait_clks(4);
    chk("ovr_drained", 32'(sb.size()), 32'd0);
    chk("ovr_valid_drop", 32'(data_out_valid), 32'h0);

    // ready asserted exactly on the completion cycle of the second frame
    data_out_ready = 1'b0;
    push(8'hAB, 1'b0, 1'b0);
    push(8'h34, 1'b0, 1'b0);
    send_frame(8'hAB, 1'b0, 1'b0, 1'b1, BIT5);
    wait_clks(32);
    fork
      send_frame(8'h34, 1'b0, 1'b0, 1'b1, BIT5);
      begin
        int n;
        n = 0;
        while (!busy && n < 2000) begin wait_clks(1); n++; end
        while (busy && n < 4000) begin wait_clks(1); n++; end
        chk("cc_done_seen", 32'(busy), 32'h0);
        data_out_ready = 1'b1;
        wait_clks(1);
        data_out_ready = 1'b0;
      end
    join
    chk("cc_data", 32'(data_out), 32'h34);
    chk("cc_valid", 32'(data_out_valid), 32'h1);
    chk("cc_no_ovr", 32'(ovr_seen), 32'd1);
    chk("cc_ab_taken", 32'(sb.size()), 32'd1);
    data_out_ready = 1'b1;
    wait_clks(4);
    chk("cc_drained", 32'(sb.size()), 32'd0);

    // reset in the middle of a frame
    send_bit(1'b0, BIT5);
    send_bit(1'b1, BIT5);
    send_bit(1'b0, BIT5);
    chk("mid_busy", 32'(busy), 32'h1);
    rxd = 1'b1;
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    chk("mid_abort_busy", 32'(busy), 32'h0);
    chk("mid_abort_valid", 32'(data_out_valid), 32'h0);
    wait_clks(11 * BIT5);
    chk("mid_no_byte", 32'(data_out_valid), 32'h0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
